// File: rtl/maf_pipe_stage.sv
// Elastic MAF pipeline register: carry/sum pair plus side-band with valid/ready,
// optional skid buffer (registered in_ready), synchronous flush and a stall counter.
module maf_pipe_stage #(
    parameter int CS_W      = 48,
    parameter int SIDE_W    = 111,
    parameter int REG_RDY   = 1,
    parameter int ZERO_KILL = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              stat_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CS_W-1:0]   in_carry,
    input  logic [CS_W-1:0]   in_sum,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CS_W-1:0]   out_carry,
    output logic [CS_W-1:0]   out_sum,
    output logic [SIDE_W-1:0] out_side,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    localparam int PAY_W = 2 * CS_W + SIDE_W;

    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

    state_t             state;
    logic [PAY_W-1:0]   in_pay_p0;
    logic [PAY_W-1:0]   m_pay_p1;
    logic [PAY_W-1:0]   s_pay_p1;
    logic               accept;
    logic               emit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign in_pay_p0 = {in_carry, in_sum, in_side};
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    // Skid mode decodes ready from state only, so out_ready never reaches in_ready.
    always_comb begin
        if (REG_RDY != 0) in_ready = (state != SKID);
        else              in_ready = (state == EMPTY) || out_ready;
    end

    always_comb begin
        unique case (state)
            FULL:    occupancy = 2'd1;
            SKID:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // ---- stage p0 -> p1: main register M and skid register S ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= EMPTY;
            m_pay_p1 <= '0;
            s_pay_p1 <= '0;
        end else if (flush) begin
            state <= EMPTY;
            if (ZERO_KILL != 0) begin
                m_pay_p1 <= '0;
                s_pay_p1 <= '0;
            end
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        m_pay_p1 <= in_pay_p0;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    if (accept && emit) begin
                        m_pay_p1 <= in_pay_p0;
                    end else if (accept) begin
                        s_pay_p1 <= in_pay_p0;
                        state    <= SKID;
                    end else if (emit) begin
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    if (emit) begin
                        m_pay_p1 <= s_pay_p1;
                        state    <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign {out_carry, out_sum, out_side} = m_pay_p1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                        stall_cnt <= '0;
        else if (stat_clr)                stall_cnt <= '0;
        else if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_maf_pipe_stage.sv
// Self-checking bench for maf_pipe_stage: skid-buffered and single-entry instances
// driven from shared inputs, checked against queue-based reference models.
module tb_maf_pipe_stage;

    localparam int CS_W   = 48;
    localparam int SIDE_W = 111;
    typedef logic [2*CS_W+SIDE_W-1:0] beat_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic flush = 1'b0, stat_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [CS_W-1:0]   in_carry = '0, in_sum = '0;
    logic [SIDE_W-1:0] in_side = '0;

    logic              in_ready, out_valid;
    logic [CS_W-1:0]   out_carry, out_sum;
    logic [SIDE_W-1:0] out_side;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;

    logic              in_ready0, out_valid0;
    logic [CS_W-1:0]   out_carry0, out_sum0;
    logic [SIDE_W-1:0] out_side0;
    logic [1:0]        occupancy0;
    logic [15:0]       stall_cnt0;

    int n_assert = 0;
    int n_fail   = 0;

    beat_t       q1[$];
    beat_t       q0[$];
    logic [15:0] st1 = '0;
    logic [15:0] st0 = '0;

    always #5 clk = ~clk;

    maf_pipe_stage #(.CS_W(CS_W), .SIDE_W(SIDE_W), .REG_RDY(1), .ZERO_KILL(1)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .stat_clr(stat_clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_carry(in_carry), .in_sum(in_sum), .in_side(in_side),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_carry(out_carry), .out_sum(out_sum), .out_side(out_side),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    maf_pipe_stage #(.CS_W(CS_W), .SIDE_W(SIDE_W), .REG_RDY(0), .ZERO_KILL(1)) dut0 (
        .clk(clk), .rstn(rstn), .flush(flush), .stat_clr(stat_clr),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_carry(in_carry), .in_sum(in_sum), .in_side(in_side),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_carry(out_carry0), .out_sum(out_sum0), .out_side(out_side0),
        .occupancy(occupancy0), .stall_cnt(stall_cnt0)
    );

    // Reference: a FIFO of capacity 2 (skid) or 1 (single-entry), evaluated per clock edge.
    task automatic model_step();
        beat_t cur;
        bit e1, a1, e0, a0;
        cur = {in_carry, in_sum, in_side};
        if (!rstn) begin
            q1.delete(); q0.delete(); st1 = '0; st0 = '0;
            return;
        end
        e1 = (q1.size() > 0) && out_ready;
        a1 = in_valid && (q1.size() < 2);
        e0 = (q0.size() > 0) && out_ready;
        a0 = in_valid && ((q0.size() == 0) || out_ready);
        if (stat_clr) st1 = '0;
        else if (q1.size() > 0 && !out_ready && st1 != 16'hFFFF) st1 = st1 + 16'd1;
        if (stat_clr) st0 = '0;
        else if (q0.size() > 0 && !out_ready && st0 != 16'hFFFF) st0 = st0 + 16'd1;
        if (flush) begin
            q1.delete(); q0.delete();
        end else begin
            if (e1) void'(q1.pop_front());
            if (a1) q1.push_back(cur);
            if (e0) void'(q0.pop_front());
            if (a0) q0.push_back(cur);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_side = r[SIDE_W-1:0];
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_carry = r[CS_W-1:0];
        in_sum   = r[64+CS_W-1:64];
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #1;
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_assert++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready0: got %b expected 1", in_ready0); end
        n_assert++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_assert++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        n_assert++; if ({out_carry, out_sum, out_side} !== '0) begin n_fail++; $display("FAIL reset_payload: got %h expected 0", {out_carry, out_sum, out_side}); end
        tick(); tick();
        rstn = 1'b1;
        #1;
        n_assert++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL release_handshake: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_first_beat();
        out_ready = 1'b1; in_valid = 1'b1;
        in_carry = 48'h1; in_sum = 48'h2; in_side = 111'h3;
        tick();
        in_valid = 1'b0;
        n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b expected 1", out_valid); end
        n_assert++; if (out_carry !== 48'h1 || out_sum !== 48'h2) begin n_fail++; $display("FAIL first_cs: got carry=%h sum=%h expected 1/2", out_carry, out_sum); end
        n_assert++; if (out_side !== 111'h3) begin n_fail++; $display("FAIL first_side: got %h expected 3", out_side); end
        n_assert++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL first_occupancy: got %0d expected 1", occupancy); end
        tick();
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_carry = 48'(i);
            in_sum   = ~48'(i);
            in_side  = 111'(i * 7);
            tick();
            n_assert++;
            if (out_valid !== 1'b1 || out_carry !== 48'(i) || out_sum !== ~48'(i)) begin
                n_fail++;
                $display("FAIL stream_beat%0d: got valid=%b carry=%h sum=%h expected 1/%h/%h", i, out_valid, out_carry, out_sum, 48'(i), ~48'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid: got %b expected 0", out_valid); end
        n_assert++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_stall: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_skid();
        logic [CS_W-1:0] a, b;
        out_ready = 1'b1; in_valid = 1'b0; stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        rand_beat(); a = in_carry;
        tick();
        rand_beat(); b = in_carry;
        tick();
        in_valid = 1'b0;
        n_assert++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL skid_occupancy: got %0d expected 2", occupancy); end
        n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_in_ready: got %b expected 0", in_ready); end
        n_assert++; if (out_carry !== a) begin n_fail++; $display("FAIL skid_hold_a: got %h expected %h", out_carry, a); end
        tick();
        n_assert++; if (out_carry !== a || stall_cnt !== 16'd2) begin n_fail++; $display("FAIL skid_stall: got carry=%h stall=%0d expected %h/2", out_carry, stall_cnt, a); end
        out_ready = 1'b1;
        tick();
        n_assert++; if (out_valid !== 1'b1 || out_carry !== b || occupancy !== 2'd1) begin n_fail++; $display("FAIL skid_emit_b: got valid=%b carry=%h occ=%0d expected 1/%h/1", out_valid, out_carry, occupancy, b); end
        tick();
        n_assert++; if (out_valid !== 1'b0 || stall_cnt !== 16'd2) begin n_fail++; $display("FAIL skid_drain: got valid=%b stall=%0d expected 0/2", out_valid, stall_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        rand_beat(); tick();
        rand_beat(); tick();
        n_assert++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d expected 2", occupancy); end
        flush = 1'b1; rand_beat();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_assert++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_state: got valid=%b occ=%0d expected 0/0", out_valid, occupancy); end
        n_assert++; if ({out_carry, out_sum, out_side} !== '0) begin n_fail++; $display("FAIL flush_zero: got %h expected 0", {out_carry, out_sum, out_side}); end
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        n_assert++; if (stall_cnt !== st1) begin n_fail++; $display("FAIL flush_stall_kept: got %0d expected %0d", stall_cnt, st1); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_emit%0d: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_reg_rdy0();
        logic [CS_W-1:0] x, y;
        flush = 1'b1; tick(); flush = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        rand_beat(); x = in_carry;
        #1;
        n_assert++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL rr0_empty_ready: got %b expected 1", in_ready0); end
        tick();
        rand_beat(); y = in_carry;
        #1;
        n_assert++; if (in_ready0 !== 1'b0 || occupancy0 !== 2'd1) begin n_fail++; $display("FAIL rr0_full_block: got ready=%b occ=%0d expected 0/1", in_ready0, occupancy0); end
        tick();
        n_assert++; if (out_carry0 !== x || occupancy0 !== 2'd1) begin n_fail++; $display("FAIL rr0_hold: got carry=%h occ=%0d expected %h/1", out_carry0, occupancy0, x); end
        out_ready = 1'b1;
        #1;
        n_assert++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL rr0_comb_ready: got %b expected 1", in_ready0); end
        tick();
        in_valid = 1'b0;
        n_assert++; if (out_valid0 !== 1'b1 || out_carry0 !== y) begin n_fail++; $display("FAIL rr0_replace: got valid=%b carry=%h expected 1/%h", out_valid0, out_carry0, y); end
        tick();
    endtask

    task automatic test_random();
        bit exp_rdy0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            stat_clr  = ($urandom_range(0, 29) == 0);
            rand_beat();
            #1;
            exp_rdy0 = (q0.size() == 0) || out_ready;
            n_assert++; if (in_ready0 !== exp_rdy0) begin n_fail++; $display("FAIL rand_in_ready0 c%0d: got %b expected %b", c, in_ready0, exp_rdy0); end
            tick();
            n_assert++; if (out_valid !== (q1.size() != 0) || occupancy !== 2'(q1.size()) || in_ready !== (q1.size() < 2)) begin
                n_fail++; $display("FAIL rand_ctl c%0d: got valid=%b occ=%0d ready=%b expected occ=%0d", c, out_valid, occupancy, in_ready, q1.size());
            end
            if (q1.size() != 0) begin
                n_assert++; if ({out_carry, out_sum, out_side} !== q1[0]) begin n_fail++; $display("FAIL rand_data c%0d: got %h expected %h", c, {out_carry, out_sum, out_side}, q1[0]); end
            end
            n_assert++; if (stall_cnt !== st1 || stall_cnt0 !== st0) begin n_fail++; $display("FAIL rand_stall c%0d: got %0d/%0d expected %0d/%0d", c, stall_cnt, stall_cnt0, st1, st0); end
            n_assert++; if (out_valid0 !== (q0.size() != 0) || occupancy0 !== 2'(q0.size())) begin
                n_fail++; $display("FAIL rand_ctl0 c%0d: got valid=%b occ=%0d expected occ=%0d", c, out_valid0, occupancy0, q0.size());
            end
            if (q0.size() != 0) begin
                n_assert++; if ({out_carry0, out_sum0, out_side0} !== q0[0]) begin n_fail++; $display("FAIL rand_data0 c%0d: got %h expected %h", c, {out_carry0, out_sum0, out_side0}, q0[0]); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic test_stall_sat();
        flush = 1'b1; tick(); flush = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; rand_beat();
        tick();
        in_valid = 1'b0;
        repeat (70000) tick();
        n_assert++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_saturate: got %h expected ffff", stall_cnt); end
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        n_assert++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_clear: got %0d expected 0", stall_cnt); end
        tick();
        n_assert++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_after_clr1: got %0d expected 1", stall_cnt); end
        tick();
        n_assert++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL stall_after_clr2: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_reset_mid();
        flush = 1'b1; tick(); flush = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        rand_beat(); tick();
        rand_beat(); tick();
        in_valid = 1'b0;
        #3 rstn = 1'b0;
        #1;
        n_assert++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ctl: got valid=%b occ=%0d ready=%b expected 0/0/1", out_valid, occupancy, in_ready); end
        n_assert++; if ({out_carry, out_sum, out_side} !== '0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_data: got %h stall=%0d expected 0/0", {out_carry, out_sum, out_side}, stall_cnt); end
        tick();
        rstn = 1'b1;
        out_ready = 1'b1;
        tick();
        n_assert++; if (out_valid !== 1'b0 || out_valid0 !== 1'b0) begin n_fail++; $display("FAIL midrst_no_emit: got %b/%b expected 0/0", out_valid, out_valid0); end
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_streaming();
        test_skid();
        test_flush();
        test_reg_rdy0();
        test_random();
        test_stall_sat();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
